// File: rtl/branch_stall_ctrl_if.sv
// Pipeline-side signal bundle for the ID-stage hazard sequencer.
// master = pipeline (drives hazard inputs), slave = branch_stall_ctrl.
interface branch_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_rs;
    logic [4:0]       IF_ID_rt;
    logic             ID_uses_rt;
    logic             ID_Branch;
    logic             ID_BranchTaken;
    logic [4:0]       ID_EX_regres;
    logic             ID_EX_RegWrite;
    logic             ID_EX_MEMRead;
    logic [4:0]       EX_MEM_regres;
    logic             EX_MEM_RegWrite;
    logic             EX_MEM_MEMRead;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             ID_EX_Bubble;
    logic             IF_ID_Flush;
    logic             stall_active;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output IF_ID_rs, IF_ID_rt, ID_uses_rt, ID_Branch, ID_BranchTaken,
               ID_EX_regres, ID_EX_RegWrite, ID_EX_MEMRead,
               EX_MEM_regres, EX_MEM_RegWrite, EX_MEM_MEMRead,
        input  PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
               stall_active, stall_cycles
    );

    modport slave (
        input  IF_ID_rs, IF_ID_rt, ID_uses_rt, ID_Branch, ID_BranchTaken,
               ID_EX_regres, ID_EX_RegWrite, ID_EX_MEMRead,
               EX_MEM_regres, EX_MEM_RegWrite, EX_MEM_MEMRead,
        output PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
               stall_active, stall_cycles
    );
endinterface

// File: rtl/branch_stall_ctrl.sv
// ID-stage hazard sequencer: freezes PC/IF-ID and bubbles ID/EX when the branch
// comparator or a load consumer cannot be served by forwarding yet.
module branch_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_stall_ctrl_if.slave bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m_ex_s, m_mem_s, h1_s, h2_s, stall_s;

    // Hazard classification and FSM next-state; a load feeding a branch needs two bubbles.
    always_comb begin
        m_ex_s  = bus.ID_EX_RegWrite & (bus.ID_EX_regres != 5'd0) &
                  ((bus.ID_EX_regres == bus.IF_ID_rs) |
                   (bus.ID_uses_rt & (bus.ID_EX_regres == bus.IF_ID_rt)));
        m_mem_s = bus.EX_MEM_RegWrite & (bus.EX_MEM_regres != 5'd0) &
                  ((bus.EX_MEM_regres == bus.IF_ID_rs) |
                   (bus.ID_uses_rt & (bus.EX_MEM_regres == bus.IF_ID_rt)));
        h2_s    = bus.ID_Branch & m_ex_s & bus.ID_EX_MEMRead;
        h1_s    = (bus.ID_Branch & m_ex_s & ~bus.ID_EX_MEMRead) |
                  (bus.ID_Branch & m_mem_s & bus.EX_MEM_MEMRead) |
                  (~bus.ID_Branch & m_ex_s & bus.ID_EX_MEMRead);
        stall_s = 1'b1;
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                stall_s = h1_s | h2_s;
                state_d = h2_s ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                stall_s = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                stall_s = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating bubble-cycle counter for performance debug.
    always_comb begin
        if (stall_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Zero-latency pipeline controls; during reset the pipeline is held frozen and bubbled.
    always_comb begin
        bus.stall_cycles = cnt_q;
        if (!rst_n) begin
            bus.PC_Write     = 1'b0;
            bus.IF_ID_Write  = 1'b0;
            bus.ID_EX_Bubble = 1'b1;
            bus.stall_active = 1'b1;
            bus.IF_ID_Flush  = 1'b0;
        end else begin
            bus.PC_Write     = ~stall_s;
            bus.IF_ID_Write  = ~stall_s;
            bus.ID_EX_Bubble = stall_s;
            bus.stall_active = stall_s;
            bus.IF_ID_Flush  = bus.ID_Branch & bus.ID_BranchTaken & ~stall_s;
        end
    end
endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Directed bench for branch_stall_ctrl: a bubbles-remaining model checks every
// cycle, and literal expectations pin the model at the key points of each scenario.
module tb_branch_stall_ctrl;
    localparam int CNT_W = 4;
    localparam int CNT_SAT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    int   m_rem = 0;
    int   m_cnt = 0;

    branch_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    branch_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bubbles the current ID instruction still needs, straight from the hazard rules.
    function automatic int need_bubbles();
        logic mex, mmem;
        mex  = bus.ID_EX_RegWrite && (bus.ID_EX_regres != 5'd0) &&
               ((bus.ID_EX_regres == bus.IF_ID_rs) ||
                (bus.ID_uses_rt && (bus.ID_EX_regres == bus.IF_ID_rt)));
        mmem = bus.EX_MEM_RegWrite && (bus.EX_MEM_regres != 5'd0) &&
               ((bus.EX_MEM_regres == bus.IF_ID_rs) ||
                (bus.ID_uses_rt && (bus.EX_MEM_regres == bus.IF_ID_rt)));
        if (bus.ID_Branch && mex && bus.ID_EX_MEMRead) return 2;
        if (bus.ID_Branch && mex) return 1;
        if (bus.ID_Branch && mmem && bus.EX_MEM_MEMRead) return 1;
        if (!bus.ID_Branch && mex && bus.ID_EX_MEMRead) return 1;
        return 0;
    endfunction

    // Model update on the clock edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem = 0;
            m_cnt = 0;
        end else begin
            int n;
            bit st;
            n  = need_bubbles();
            st = (m_rem > 0) || (n > 0);
            if (m_rem > 0) m_rem = m_rem - 1;
            else if (n > 0) m_rem = n - 1;
            if (st && m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
        end
    end

    // Per-cycle compare on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            bit st;
            st = rst_n ? ((m_rem > 0) || (need_bubbles() > 0)) : 1'b1;
            cmp("pc_write",  {31'd0, bus.PC_Write},     {31'd0, ~st});
            cmp("ifid_write",{31'd0, bus.IF_ID_Write},  {31'd0, ~st});
            cmp("bubble",    {31'd0, bus.ID_EX_Bubble}, {31'd0, st});
            cmp("stall_act", {31'd0, bus.stall_active}, {31'd0, st});
            cmp("flush",     {31'd0, bus.IF_ID_Flush},
                {31'd0, rst_n & bus.ID_Branch & bus.ID_BranchTaken & ~st});
            cmp("stall_cyc", {28'd0, bus.stall_cycles}, m_cnt);
        end
    end

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic br, input logic tk,
                         input logic [4:0] exrd, input logic exwr, input logic exld,
                         input logic [4:0] memrd, input logic memwr, input logic memld);
        bus.IF_ID_rs        = rs;
        bus.IF_ID_rt        = rt;
        bus.ID_uses_rt      = urt;
        bus.ID_Branch       = br;
        bus.ID_BranchTaken  = tk;
        bus.ID_EX_regres    = exrd;
        bus.ID_EX_RegWrite  = exwr;
        bus.ID_EX_MEMRead   = exld;
        bus.EX_MEM_regres   = memrd;
        bus.EX_MEM_RegWrite = memwr;
        bus.EX_MEM_MEMRead  = memld;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        chk_en = 1'b1;
        step();
        cmp("rst_pc",    {31'd0, bus.PC_Write}, 32'd0);
        cmp("rst_bub",   {31'd0, bus.ID_EX_Bubble}, 32'd1);
        cmp("rst_flush", {31'd0, bus.IF_ID_Flush}, 32'd0);
        cmp("rst_cnt",   {28'd0, bus.stall_cycles}, 32'd0);
        rst_n = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cmp("idle_pc", {31'd0, bus.PC_Write}, 32'd1);

        // load-use: lw $5 in EX, add using $5 in ID
        step();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        cmp("lu_pc",  {31'd0, bus.PC_Write}, 32'd0);
        cmp("lu_bub", {31'd0, bus.ID_EX_Bubble}, 32'd1);
        step();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        cmp("lu_go",  {31'd0, bus.PC_Write}, 32'd1);
        cmp("lu_cnt", {28'd0, bus.stall_cycles}, 32'd1);

        // branch after ALU producer
        step();
        drive(5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        cmp("ba_bub",   {31'd0, bus.ID_EX_Bubble}, 32'd1);
        cmp("ba_noflu", {31'd0, bus.IF_ID_Flush}, 32'd0);
        step();
        drive(5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        cmp("ba_flush", {31'd0, bus.IF_ID_Flush}, 32'd1);
        cmp("ba_cnt",   {28'd0, bus.stall_cycles}, 32'd2);

        // branch after load, match on rt
        step();
        drive(5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        cmp("bl_bub1", {31'd0, bus.ID_EX_Bubble}, 32'd1);
        step();
        drive(5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
        cmp("bl_bub2", {31'd0, bus.ID_EX_Bubble}, 32'd1);
        cmp("bl_noflu",{31'd0, bus.IF_ID_Flush}, 32'd0);
        step();
        drive(5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cmp("bl_go",   {31'd0, bus.ID_EX_Bubble}, 32'd0);
        cmp("bl_cnt",  {28'd0, bus.stall_cycles}, 32'd4);

        // forwardable or harmless cases: no stall
        step();
        drive(5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
        cmp("ns_fwd", {31'd0, bus.PC_Write}, 32'd1);
        step();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1);
        cmp("ns_r0", {31'd0, bus.ID_EX_Bubble}, 32'd0);
        step();
        drive(5'd2, 5'd6, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        cmp("ns_nort", {31'd0, bus.ID_EX_Bubble}, 32'd0);

        // matches on rs, rt, EX and MEM together: one 2-bubble sequence
        step();
        drive(5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1);
        step();
        drive(5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        drive(5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cmp("mm_go",  {31'd0, bus.PC_Write}, 32'd1);
        cmp("mm_cnt", {28'd0, bus.stall_cycles}, 32'd6);

        // reset during HOLD
        step();
        drive(5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cmp("rh_pc",    {31'd0, bus.PC_Write}, 32'd0);
        cmp("rh_bub",   {31'd0, bus.stall_active}, 32'd1);
        cmp("rh_flush", {31'd0, bus.IF_ID_Flush}, 32'd0);
        step();
        cmp("rh_cnt", {28'd0, bus.stall_cycles}, 32'd0);
        rst_n = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cmp("rh_go", {31'd0, bus.PC_Write}, 32'd1);

        // saturation under continuous load-use
        step();
        drive(5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        repeat (20) step();
        cmp("sat_cnt", {28'd0, bus.stall_cycles}, 32'd15);
        cmp("sat_bub", {31'd0, bus.ID_EX_Bubble}, 32'd1);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        cmp("sat_hold", {28'd0, bus.stall_cycles}, 32'd15);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
